// File: rtl/delivery_lane_engine.sv
// Delivery-game core: scrolling multi-lane map with LFSR spawning, lane control,
// collision/pickup detection, lives, score and the win/lose state machine.
module delivery_lane_engine #(
  parameter int          LANES        = 16,
  parameter int          LENGTH       = 32,
  parameter int          BASE_PERIOD  = 64,
  parameter int          OBST_DENSITY = 4,
  parameter int          OBJ_DENSITY  = 3,
  parameter int          LIVES        = 3,
  parameter int          SCORE_W      = 3,
  parameter int          WIN_SCORE    = 7,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       jogar,
  input  logic                       pausar,
  input  logic                       move_left,
  input  logic                       move_right,
  input  logic [1:0]                 velocidade,
  output logic [3:0]                 estado,
  output logic [SCORE_W-1:0]         pontuacao,
  output logic [1:0]                 vidas,
  output logic                       pronto,
  output logic                       game_over,
  output logic                       venceu,
  output logic                       db_step,
  output logic [$clog2(LANES)-1:0]   db_player_position,
  output logic [LANES*LENGTH-1:0]    db_map_obstacle,
  output logic [LANES*LENGTH-1:0]    db_map_objective
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(BASE_PERIOD + 1);
  localparam int MW = LANES * LENGTH;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_PLAYING   = 4'd2,
    S_PAUSED    = 4'd3,
    S_GAME_OVER = 4'd4,
    S_WON       = 4'd5
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      period_q, period_d;
  logic [LW-1:0]      pos_q, pos_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MW-1:0]      obs_q, obs_d;
  logic [MW-1:0]      obj_q, obj_d;

  logic               step;
  logic               start;
  logic               hit_obs, hit_obj;
  logic [LANES-1:0]   col0_obs, col0_obj;
  logic [SCORE_W-1:0] score_inc;
  logic [CW-1:0]      next_period;
  logic [LW-1:0]      obs_lane, obj_lane;
  logic               spawn_obs, spawn_obj;

  // NOTE: every variable gets its default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d    = cnt_q;
    period_d = period_q;
    pos_d    = pos_q;
    lives_d  = lives_q;
    score_d  = score_q;
    obs_d    = obs_q;
    obj_d    = obj_q;
    start    = 1'b0;

    for (int l = 0; l < LANES; l++) begin
      col0_obs[l] = obs_q[l*LENGTH];
      col0_obj[l] = obj_q[l*LENGTH];
    end
    hit_obs     = col0_obs[pos_q];
    hit_obj     = col0_obj[pos_q];
    score_inc   = score_q + SCORE_W'(1);
    next_period = CW'(BASE_PERIOD) >> velocidade;
    step        = (state_q == S_PLAYING) && (cnt_q == period_q - CW'(1));

    obs_lane  = lfsr_q[8 +: LW];
    obj_lane  = lfsr_q[12 +: LW];
    spawn_obs = {1'b0, lfsr_q[3:0]} < 5'(OBST_DENSITY);
    spawn_obj = {1'b0, lfsr_q[7:4]} < 5'(OBJ_DENSITY);

    case (state_q)
      S_IDLE, S_GAME_OVER, S_WON: start = jogar;
      S_INIT:   state_d = S_PLAYING;
      S_PAUSED: if (pausar) state_d = S_PLAYING;
      S_PLAYING: begin
        if (pausar) state_d = S_PAUSED;

        if (move_left && !move_right && pos_q != '0)
          pos_d = pos_q - LW'(1);
        else if (move_right && !move_left && pos_q != LW'(LANES-1))
          pos_d = pos_q + LW'(1);

        if (hit_obj) begin
          score_d = score_inc;
          if (score_inc == SCORE_W'(WIN_SCORE)) state_d = S_WON;
        end
        // Losing the last life overrides a simultaneous win.
        if (hit_obs) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_GAME_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end

        if (step) begin
          cnt_d    = '0;
          period_d = next_period;
          for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < LENGTH-1; c++) begin
              obs_d[l*LENGTH+c] = obs_q[l*LENGTH+c+1];
              obj_d[l*LENGTH+c] = obj_q[l*LENGTH+c+1];
            end
            obs_d[l*LENGTH+LENGTH-1] = spawn_obs && (obs_lane == LW'(l));
            obj_d[l*LENGTH+LENGTH-1] = spawn_obj && (obj_lane == LW'(l)) &&
                                       !(spawn_obs && obs_lane == obj_lane);
          end
        end else begin
          // The pausing cycle already freezes the counter so resume picks up where it left off.
          if (!pausar) cnt_d = cnt_q + CW'(1);
          for (int l = 0; l < LANES; l++) begin
            if (pos_q == LW'(l)) begin
              obs_d[l*LENGTH] = 1'b0;
              obj_d[l*LENGTH] = 1'b0;
            end
          end
        end

        if (state_d != S_PLAYING && state_d != S_PAUSED) cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d  = S_INIT;
      obs_d    = '0;
      obj_d    = '0;
      score_d  = '0;
      lives_d  = 2'(LIVES);
      pos_d    = LW'(LANES/2);
      cnt_d    = '0;
      period_d = next_period;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      cnt_q    <= '0;
      period_q <= CW'(BASE_PERIOD);
      pos_q    <= '0;
      lives_q  <= 2'd0;
      score_q  <= '0;
      obs_q    <= '0;
      obj_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      obs_q    <= obs_d;
      obj_q    <= obj_d;
    end
  end

  assign estado             = state_q;
  assign pontuacao          = score_q;
  assign vidas              = lives_q;
  assign game_over          = (state_q == S_GAME_OVER);
  assign venceu             = (state_q == S_WON);
  assign pronto             = game_over || venceu;
  assign db_step            = step;
  assign db_player_position = pos_q;
  assign db_map_obstacle    = obs_q;
  assign db_map_objective   = obj_q;

endmodule

// File: tb/tb_delivery_lane_engine.sv
// Directed bench: timer/pause/movement on a 16-lane map, game-over on a 2-lane
// map and a steered win on a 4-lane map, each checked against hand-derived values.
module tb_delivery_lane_engine;

  logic clock = 1'b0;
  logic reset, pausar, move_left, move_right;
  logic [1:0] velocidade;
  logic a_jogar, b_jogar, c_jogar;

  logic [3:0]   a_estado, b_estado, c_estado;
  logic [2:0]   a_score, b_score, c_score;
  logic [1:0]   a_vidas, b_vidas, c_vidas;
  logic         a_pronto, a_go, a_win, a_step;
  logic         b_pronto, b_go, b_win, b_step;
  logic         c_pronto, c_go, c_win, c_step;
  logic [3:0]   a_pos;
  logic [0:0]   b_pos;
  logic [1:0]   c_pos;
  logic [511:0] a_obs, a_obj;
  logic [7:0]   b_obs, b_obj;
  logic [15:0]  c_obs, c_obj;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  mb_obs;
  logic [15:0] mc_obj;
  int          mpos, mscore;
  bit          done;

  delivery_lane_engine #(.LANES(16), .LENGTH(32), .BASE_PERIOD(8), .OBST_DENSITY(0),
                         .OBJ_DENSITY(0), .LIVES(3)) u_a (
    .clock(clock), .reset(reset), .jogar(a_jogar), .pausar(pausar),
    .move_left(move_left), .move_right(move_right), .velocidade(velocidade),
    .estado(a_estado), .pontuacao(a_score), .vidas(a_vidas), .pronto(a_pronto),
    .game_over(a_go), .venceu(a_win), .db_step(a_step), .db_player_position(a_pos),
    .db_map_obstacle(a_obs), .db_map_objective(a_obj));

  delivery_lane_engine #(.LANES(2), .LENGTH(4), .BASE_PERIOD(8), .OBST_DENSITY(16),
                         .OBJ_DENSITY(0), .LIVES(1)) u_b (
    .clock(clock), .reset(reset), .jogar(b_jogar), .pausar(pausar),
    .move_left(move_left), .move_right(move_right), .velocidade(velocidade),
    .estado(b_estado), .pontuacao(b_score), .vidas(b_vidas), .pronto(b_pronto),
    .game_over(b_go), .venceu(b_win), .db_step(b_step), .db_player_position(b_pos),
    .db_map_obstacle(b_obs), .db_map_objective(b_obj));

  delivery_lane_engine #(.LANES(4), .LENGTH(4), .BASE_PERIOD(8), .OBST_DENSITY(0),
                         .OBJ_DENSITY(16), .LIVES(3), .WIN_SCORE(2)) u_c (
    .clock(clock), .reset(reset), .jogar(c_jogar), .pausar(pausar),
    .move_left(move_left), .move_right(move_right), .velocidade(velocidade),
    .estado(c_estado), .pontuacao(c_score), .vidas(c_vidas), .pronto(c_pronto),
    .game_over(c_go), .venceu(c_win), .db_step(c_step), .db_player_position(c_pos),
    .db_map_obstacle(c_obs), .db_map_objective(c_obj));

  always #5 clock = ~clock;

  // Reference LFSR: all three instances share clock and reset, so one model serves them all.
  always @(posedge clock)
    m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_move(input logic l, input logic r, input int n);
    move_left  = l;
    move_right = r;
    repeat (n) tick();
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pausar = 1'b0; move_left = 1'b0; move_right = 1'b0;
    velocidade = 2'd0; a_jogar = 1'b0; b_jogar = 1'b0; c_jogar = 1'b0;
    tick(); tick();
    check("rst_estado", a_estado, 0);
    check("rst_vidas", a_vidas, 0);
    check("rst_score", a_score, 0);
    check("rst_pos", a_pos, 0);
    check("rst_maps", |{a_obs, a_obj}, 0);
    check("rst_step", a_step, 0);
    check("rst_flags", {a_pronto, a_go, a_win}, 0);
    reset = 1'b0;

    // Start A: IDLE -> INIT -> PLAYING
    a_jogar = 1'b1; tick(); a_jogar = 1'b0;
    check("a_init_estado", a_estado, 1);
    check("a_init_vidas", a_vidas, 3);
    check("a_init_pos", a_pos, 8);
    check("a_init_score", a_score, 0);
    tick();
    check("a_play_estado", a_estado, 2);

    // Period 8, then speed 3 takes effect after the wrap at cycle 23, back to 8 after cycle 28
    for (int i = 0; i < 34; i++) begin
      if (i == 16) velocidade = 2'd3;
      if (i == 28) velocidade = 2'd0;
      check($sformatf("a_step_%0d", i), a_step,
            (i < 24) ? ((i % 8) == 7) : (i <= 28));
      tick();
    end

    // Counter is 5 here; pause, hold with move pulses, resume
    check("a_step_34", a_step, 0);
    pausar = 1'b1; tick(); pausar = 1'b0;
    check("a_paused", a_estado, 3);
    for (int k = 0; k < 20; k++) begin
      move_left  = k[0];
      move_right = (k == 7);
      tick();
      check("a_pause_step", a_step, 0);
    end
    move_left = 1'b0; move_right = 1'b0;
    check("a_pause_pos", a_pos, 8);
    check("a_pause_estado", a_estado, 3);
    pausar = 1'b1; tick(); pausar = 1'b0;
    check("a_resume", a_estado, 2);
    check("a_resume_u0", a_step, 0);
    tick();
    check("a_resume_u1", a_step, 0);
    tick();
    check("a_resume_u2", a_step, 1);

    drive_move(1'b1, 1'b0, 10);
    check("a_left_to_0", a_pos, 0);
    drive_move(1'b1, 1'b0, 1);
    check("a_left_sat", a_pos, 0);
    drive_move(1'b0, 1'b1, 20);
    check("a_right_to_15", a_pos, 15);
    drive_move(1'b0, 1'b1, 1);
    check("a_right_sat", a_pos, 15);
    drive_move(1'b1, 1'b0, 7);
    check("a_back_to_8", a_pos, 8);
    drive_move(1'b1, 1'b1, 3);
    check("a_both", a_pos, 8);
    a_jogar = 1'b1; tick(); a_jogar = 1'b0;
    check("a_jogar_ignored", a_estado, 2);
    check("a_vidas_kept", a_vidas, 3);
    check("a_maps_empty", |{a_obs, a_obj}, 0);

    reset = 1'b1; tick(); reset = 1'b0;
    check("a_midreset_estado", a_estado, 0);
    check("a_midreset_vidas", a_vidas, 0);
    check("a_midreset_pos", a_pos, 0);

    // B: every step spawns an obstacle; player stays in lane 1 until one arrives
    b_jogar = 1'b1; tick(); b_jogar = 1'b0;
    check("b_init_estado", b_estado, 1);
    check("b_init_vidas", b_vidas, 1);
    check("b_init_pos", b_pos, 1);
    tick();
    check("b_play_estado", b_estado, 2);
    mb_obs = '0;
    done   = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      check("b_step", b_step, (i % 8) == 7);
      if (mb_obs[4]) begin
        mb_obs[4] = 1'b0;
        done      = 1'b1;
      end else if ((i % 8) == 7) begin
        for (int l = 0; l < 2; l++) begin
          for (int c = 0; c < 3; c++) mb_obs[l*4+c] = mb_obs[l*4+c+1];
          mb_obs[l*4+3] = (int'(m_lfsr[8]) == l);
        end
      end
      tick();
      check("b_obs_map", b_obs, mb_obs);
      check("b_estado", b_estado, done ? 4 : 2);
    end
    if (!done) check("b_timeout", 0, 1);
    check("b_vidas_0", b_vidas, 0);
    check("b_flags", {b_pronto, b_go, b_win}, 3'b110);
    check("b_obj_empty", b_obj, 0);
    tick(); tick();
    check("b_hold_map", b_obs, mb_obs);
    check("b_hold_estado", b_estado, 4);

    // C: every step spawns an objective; steer toward any objective in column 0
    c_jogar = 1'b1; tick(); c_jogar = 1'b0;
    check("c_init_estado", c_estado, 1);
    check("c_init_pos", c_pos, 2);
    tick();
    check("c_play_estado", c_estado, 2);
    mc_obj = '0;
    mpos   = 2;
    mscore = 0;
    done   = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      bit hit;
      int tgt;
      int npos;
      hit = mc_obj[mpos*4];
      tgt = -1;
      for (int l = 0; l < 4; l++) if (mc_obj[l*4]) tgt = l;
      move_left  = !hit && tgt >= 0 && tgt < mpos;
      move_right = !hit && tgt > mpos;
      npos = mpos;
      if (move_left && npos > 0) npos--;
      if (move_right && npos < 3) npos++;
      if (hit) begin
        mscore++;
        if (mscore == 2) done = 1'b1;
      end
      if ((i % 8) == 7) begin
        for (int l = 0; l < 4; l++) begin
          for (int c = 0; c < 3; c++) mc_obj[l*4+c] = mc_obj[l*4+c+1];
          mc_obj[l*4+3] = (int'(m_lfsr[13:12]) == l);
        end
      end else if (hit) begin
        mc_obj[mpos*4] = 1'b0;
      end
      mpos = npos;
      tick();
      check("c_pos", c_pos, mpos);
      check("c_score", c_score, mscore);
      check("c_obj_map", c_obj, mc_obj);
      check("c_estado", c_estado, done ? 5 : 2);
    end
    move_left = 1'b0; move_right = 1'b0;
    if (!done) check("c_timeout", 0, 1);
    check("c_won_flags", {c_pronto, c_go, c_win}, 3'b101);
    check("c_won_score", c_score, 2);
    check("c_obs_empty", c_obs, 0);

    c_jogar = 1'b1; tick(); c_jogar = 1'b0;
    check("c_restart_estado", c_estado, 1);
    check("c_restart_score", c_score, 0);
    check("c_restart_vidas", c_vidas, 3);
    check("c_restart_map", c_obj, 0);
    check("c_restart_venceu", c_win, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
